// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address and
// captures the returned word into the IR for decode, with stall, redirect and HALT handling.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 17,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]        HALT_OPC = 5'h1F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              is_halt;

  assign imem_addr = pc;
  assign is_halt   = (imem_rdata[INSTR_W-1 -: 5] == HALT_OPC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          ir_valid <= 1'b0;
          if (redirect_valid) pc <= redirect_addr;
          if (start) state <= RUN;
        end
        RUN: begin
          // Redirect squashes the in-flight fetch and beats stall.
          if (redirect_valid) begin
            pc       <= redirect_addr;
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir       <= imem_rdata;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            if (is_halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
          end
        end
        HALTED: begin
          ir_valid <= 1'b0;
          if (redirect_valid) begin
            pc     <= redirect_addr;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          ir_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction memory interface. Owns the program counter, drives the 8-bit fetch address, and captures the returned 17-bit instruction into an instruction register for decode.
- Handles start, stall, branch/jump redirect and HALT detection.
- Sits between the instruction memory and the decode stage of the processor.

Parameters:
- ADDR_W, 8, fetch address / PC width.
- INSTR_W, 17, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPC, 5'h1F, opcode (instr[16:12]) that halts fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  level; begins fetching from IDLE.
- stall  input  1  level; decode not ready, hold everything.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_addr  input  ADDR_W  branch/jump target.
- imem_addr  output  ADDR_W  address to instruction memory, combinationally equal to pc.
- imem_rdata  input  INSTR_W  instruction returned combinationally for imem_addr.
- ir  output  INSTR_W  registered instruction to decode.
- ir_pc  output  ADDR_W  address ir was fetched from.
- ir_valid  output  1  ir holds a live instruction this cycle.
- halted  output  1  high while in HALTED.
- fetch_count  output  16  count of instructions captured, saturating.

Behaviour:
- Reset (async, any state, mid-operation included):
  - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0, state=IDLE.
  - Takes effect immediately; no partial capture completes.
- States: IDLE, RUN, HALTED. The registered state drives halted (halted=1 only in HALTED).
- IDLE:
  - ir_valid=0.
  - redirect_valid loads pc<=redirect_addr.
  - start=1 moves to RUN next edge.
  - start and redirect_valid together: pc loads the target AND the state goes to RUN.
- RUN, per rising edge, in priority order:
  1. redirect_valid: pc<=redirect_addr, ir_valid<=0 (squash the in-flight fetch), ir and ir_pc hold, fetch_count unchanged. Overrides stall.
  2. stall: pc, ir, ir_pc, ir_valid and fetch_count all hold.
  3. Otherwise: ir<=imem_rdata, ir_pc<=pc, ir_valid<=1, fetch_count+=1 (saturates at 16'hFFFF). pc<=pc+1 modulo 2^ADDR_W, so 8'hFF wraps to 8'h00 with no flag.
- HALT detection:
  - If the word being captured has imem_rdata[16:12]==HALT_OPC, the capture still occurs: ir_valid<=1, count increments.
  - pc is NOT incremented (stays at the halt address), and the state goes to HALTED.
- HALTED:
  - ir_valid<=0 on the first edge; ir and ir_pc hold.
  - start and stall are ignored.
  - redirect_valid loads pc<=redirect_addr and returns to RUN. This is the only exit other than rst.
- Latency: the word at address A appears on ir exactly one clock after imem_addr==A, when there is no stall or redirect.
- Throughput: one instruction per clock in RUN.
- imem_addr is pure combinational from pc, so the memory read and capture complete in the same cycle.
- An instruction word of all zeros is an ordinary instruction; only HALT_OPC halts.

Test Plan:
- Reset, then start=1 with memory holding 17'h00101 at 0, 17'h00202 at 1 -> imem_addr 0,1,2 on successive cycles; ir=17'h00101 with ir_pc=0, then ir=17'h00202 with ir_pc=1; fetch_count=2 after two captures.
- stall=1 for 3 cycles mid-run at pc=5 -> pc stays 5, ir/ir_valid/fetch_count frozen for 3 cycles; capture of address 5 occurs on the first edge after stall drops.
- redirect_valid=1 with redirect_addr=8'h40 while stall=1 at pc=7 -> next cycle pc=8'h40 and ir_valid=0; following cycle ir=mem[8'h40], ir_pc=8'h40.
- Start at pc=8'hFE with no halts -> captures at 8'hFE, 8'hFF, then imem_addr=8'h00; ir_pc sequence FE, FF, 00.
- mem[3]={5'h1F,12'h000} -> ir_valid=1 with ir_pc=3; next edge halted=1, ir_valid=0, imem_addr stays 3; start=1 has no effect; redirect_valid with target 8'h10 -> RUN, fetch resumes at 8'h10.
- rst asserted asynchronously mid-cycle while in RUN at pc=9 -> immediately pc=RESET_PC, ir_valid=0, fetch_count=0, halted=0, state IDLE (no fetch without start).
